// File: rtl/rv32i_types.sv
// Shared RV32I types: opcodes, store/commit controller state and latched request.
package rv32i_types;

  localparam logic [6:0] op_b_load  = 7'b0000011;
  localparam logic [6:0] op_b_store = 7'b0100011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    LD_WAIT = 3'd3,
    LD_DROP = 3'd4
  } store_ctrl_state_t;

  // One memory request as held while the data-cache port is busy.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [3:0]  rmask;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
  } mem_req_t;

endpackage

// File: rtl/store_commit_ctrl.sv
// Arbitrates the shared data-cache port between committing stores and loads.
module store_commit_ctrl
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rob_head_store,
  input  logic        sq_valid,
  input  logic [31:0] sq_addr,
  input  logic [31:0] sq_wdata,
  input  logic [3:0]  sq_wmask,
  input  logic [31:0] sq_rs1_rdata,
  input  logic [31:0] sq_rs2_rdata,
  output logic        sq_dequeue,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_rmask,
  output logic        ld_gnt,
  output logic        ld_resp,
  output logic [31:0] ld_rdata,
  input  logic        flush,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        store_done,
  output logic [31:0] store_monitor_mem_addr,
  output logic [3:0]  store_monitor_mem_wmask,
  output logic [31:0] store_monitor_mem_wdata,
  output logic [31:0] store_monitor_rs1_rdata,
  output logic [31:0] store_monitor_rs2_rdata
);

  store_ctrl_state_t state, state_next;
  mem_req_t          req_q;
  logic              store_eligible;
  logic              load_accept;

  assign store_eligible = rob_head_store & sq_valid;
  assign load_accept    = ~store_eligible & ld_req & ~flush;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the request that is about to own the cache port; held until IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (state == IDLE) begin
      if (store_eligible) begin
        req_q <= '{opcode:    op_b_store,
                   addr:      sq_addr,
                   wdata:     sq_wdata,
                   wmask:     sq_wmask,
                   rmask:     4'h0,
                   rs1_rdata: sq_rs1_rdata,
                   rs2_rdata: sq_rs2_rdata};
      end else if (load_accept) begin
        req_q <= '{opcode:    op_b_load,
                   addr:      ld_addr,
                   wdata:     32'h0,
                   wmask:     4'h0,
                   rmask:     ld_rmask,
                   rs1_rdata: 32'h0,
                   rs2_rdata: 32'h0};
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next              = state;
    sq_dequeue              = 1'b0;
    ld_gnt                  = 1'b0;
    ld_resp                 = 1'b0;
    ld_rdata                = '0;
    dmem_addr               = '0;
    dmem_rmask              = '0;
    dmem_wmask              = '0;
    dmem_wdata              = '0;
    store_done              = 1'b0;
    store_monitor_mem_addr  = '0;
    store_monitor_mem_wmask = '0;
    store_monitor_mem_wdata = '0;
    store_monitor_rs1_rdata = '0;
    store_monitor_rs2_rdata = '0;

    case (state)
      IDLE: begin
        if (store_eligible) begin
          state_next = ST_WAIT;
        end else if (load_accept) begin
          // Grant is combinational from ld_req, so qualify with rst_n to keep it low in reset.
          ld_gnt     = rst_n;
          state_next = LD_WAIT;
        end
      end
      ST_WAIT: begin
        dmem_addr  = req_q.addr;
        dmem_wdata = req_q.wdata;
        dmem_wmask = (req_q.opcode == op_b_store) ? req_q.wmask : 4'h0;
        if (dmem_resp) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        store_done              = 1'b1;
        sq_dequeue              = 1'b1;
        store_monitor_mem_addr  = req_q.addr;
        store_monitor_mem_wmask = req_q.wmask;
        store_monitor_mem_wdata = req_q.wdata;
        store_monitor_rs1_rdata = req_q.rs1_rdata;
        store_monitor_rs2_rdata = req_q.rs2_rdata;
        state_next              = IDLE;
      end
      LD_WAIT: begin
        dmem_addr  = req_q.addr;
        dmem_rmask = req_q.rmask;
        if (dmem_resp) begin
          state_next = IDLE;
          if (!flush) begin
            ld_resp  = 1'b1;
            ld_rdata = dmem_rdata;
          end
        end else if (flush) begin
          state_next = LD_DROP;
        end
      end
      LD_DROP: begin
        dmem_addr  = req_q.addr;
        dmem_rmask = req_q.rmask;
        if (dmem_resp) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_store_commit_ctrl.sv
// Self-checking bench for store_commit_ctrl: directed scenarios plus randomized traffic.
module tb_store_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rob_head_store = 1'b0;
  logic        sq_valid = 1'b0;
  logic [31:0] sq_addr = '0;
  logic [31:0] sq_wdata = '0;
  logic [3:0]  sq_wmask = '0;
  logic [31:0] sq_rs1_rdata = '0;
  logic [31:0] sq_rs2_rdata = '0;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [3:0]  ld_rmask = '0;
  logic        flush = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_resp = 1'b0;

  logic        sq_dequeue, ld_gnt, ld_resp, store_done;
  logic [31:0] ld_rdata, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_rmask, dmem_wmask, mon_wmask;
  logic [31:0] mon_addr, mon_wdata, mon_rs1, mon_rs2;

  int n_checks = 0;
  int n_errors = 0;

  store_commit_ctrl dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .rob_head_store          (rob_head_store),
    .sq_valid                (sq_valid),
    .sq_addr                 (sq_addr),
    .sq_wdata                (sq_wdata),
    .sq_wmask                (sq_wmask),
    .sq_rs1_rdata            (sq_rs1_rdata),
    .sq_rs2_rdata            (sq_rs2_rdata),
    .sq_dequeue              (sq_dequeue),
    .ld_req                  (ld_req),
    .ld_addr                 (ld_addr),
    .ld_rmask                (ld_rmask),
    .ld_gnt                  (ld_gnt),
    .ld_resp                 (ld_resp),
    .ld_rdata                (ld_rdata),
    .flush                   (flush),
    .dmem_addr               (dmem_addr),
    .dmem_rmask              (dmem_rmask),
    .dmem_wmask              (dmem_wmask),
    .dmem_wdata              (dmem_wdata),
    .dmem_rdata              (dmem_rdata),
    .dmem_resp               (dmem_resp),
    .store_done              (store_done),
    .store_monitor_mem_addr  (mon_addr),
    .store_monitor_mem_wmask (mon_wmask),
    .store_monitor_mem_wdata (mon_wdata),
    .store_monitor_rs1_rdata (mon_rs1),
    .store_monitor_rs2_rdata (mon_rs2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction (store or load), a pending
  // store retirement, and a "response dropped" flag for flushed loads.
  bit          m_busy, m_store, m_retire, m_drop;
  logic [31:0] t_addr, t_wdata, t_rs1, t_rs2;
  logic [3:0]  t_wmask, t_rmask;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_store <= 0; m_retire <= 0; m_drop <= 0;
      t_addr <= '0; t_wdata <= '0; t_rs1 <= '0; t_rs2 <= '0; t_wmask <= '0; t_rmask <= '0;
    end else if (m_retire) begin
      m_retire <= 0;
    end else if (m_busy) begin
      if (dmem_resp) begin
        m_busy <= 0;
        if (m_store) m_retire <= 1;
      end else if (!m_store && flush) begin
        m_drop <= 1;
      end
    end else if (rob_head_store && sq_valid) begin
      m_busy <= 1; m_store <= 1;
      t_addr <= sq_addr; t_wdata <= sq_wdata; t_wmask <= sq_wmask;
      t_rs1 <= sq_rs1_rdata; t_rs2 <= sq_rs2_rdata;
    end else if (ld_req && !flush) begin
      m_busy <= 1; m_store <= 0; m_drop <= 0;
      t_addr <= ld_addr; t_rmask <= ld_rmask;
    end
  end

  task automatic check_all();
    logic        e_gnt, e_resp, e_done;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_wmask, e_rmask;
    bit          addr_care, wdata_care, rdata_care, mon_care;
    e_gnt = 0; e_resp = 0; e_done = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_wmask = '0; e_rmask = '0;
    addr_care = 0; wdata_care = 0; rdata_care = 0; mon_care = 0;
    if (!rst_n) begin
      addr_care = 1; wdata_care = 1; rdata_care = 1; mon_care = 1;
    end else if (m_retire) begin
      e_done = 1; mon_care = 1;
    end else if (m_busy && m_store) begin
      e_addr = t_addr; e_wmask = t_wmask; e_wdata = t_wdata;
      addr_care = 1; wdata_care = 1;
    end else if (m_busy) begin
      e_addr = t_addr; e_rmask = t_rmask; addr_care = 1;
      if (!m_drop && dmem_resp && !flush) begin
        e_resp = 1; e_rdata = dmem_rdata; rdata_care = 1;
      end
    end else if (!(rob_head_store && sq_valid) && ld_req && !flush) begin
      e_gnt = 1;
    end
    chk("ld_gnt", ld_gnt, e_gnt);
    chk("ld_resp", ld_resp, e_resp);
    chk("store_done", store_done, e_done);
    chk("sq_dequeue", sq_dequeue, e_done);
    chk("dmem_wmask", dmem_wmask, e_wmask);
    chk("dmem_rmask", dmem_rmask, e_rmask);
    if (addr_care)  chk("dmem_addr", dmem_addr, e_addr);
    if (wdata_care) chk("dmem_wdata", dmem_wdata, e_wdata);
    if (rdata_care) chk("ld_rdata", ld_rdata, e_rdata);
    if (mon_care) begin
      chk("mon_addr", mon_addr, e_done ? t_addr : 32'h0);
      chk("mon_wmask", mon_wmask, e_done ? t_wmask : 4'h0);
      chk("mon_wdata", mon_wdata, e_done ? t_wdata : 32'h0);
      chk("mon_rs1", mon_rs1, e_done ? t_rs1 : 32'h0);
      chk("mon_rs2", mon_rs2, e_done ? t_rs2 : 32'h0);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) check_all();

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wm_cycles;
    // Reset.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #2 check_all();

    // Store: addr 0x1000_0004, wmask 1100, wdata 0xDEAD_BEEF, response on the third wait cycle.
    cyc();
    rob_head_store = 1; sq_valid = 1;
    sq_addr = 32'h1000_0004; sq_wmask = 4'b1100; sq_wdata = 32'hDEAD_BEEF;
    sq_rs1_rdata = 32'h1111_2222; sq_rs2_rdata = 32'h3333_4444;
    #2 chk("st_idle_done", store_done, 0);
    cyc();
    rob_head_store = 0; sq_valid = 0;
    sq_addr = '0; sq_wmask = '0; sq_wdata = '0; sq_rs1_rdata = '0; sq_rs2_rdata = '0;
    wm_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_resp = (i == 2);
      #2;
      if (dmem_wmask == 4'b1100 && dmem_addr == 32'h1000_0004 && dmem_wdata == 32'hDEAD_BEEF)
        wm_cycles++;
      chk("st_wait_done", store_done, 0);
      cyc();
    end
    dmem_resp = 0;
    chk("st_wmask_cycles", wm_cycles, 3);
    #2;
    chk("st_done", store_done, 1);
    chk("st_dequeue", sq_dequeue, 1);
    chk("st_mon_addr", mon_addr, 32'h1000_0004);
    chk("st_mon_wmask", mon_wmask, 4'b1100);
    chk("st_mon_wdata", mon_wdata, 32'hDEAD_BEEF);
    chk("st_mon_rs1", mon_rs1, 32'h1111_2222);
    chk("st_mon_rs2", mon_rs2, 32'h3333_4444);
    cyc();
    #2 chk("st_done_once", store_done, 0);
    chk("st_deq_once", sq_dequeue, 0);

    // Store and load requested together: store first, load granted after ST_DONE.
    cyc();
    rob_head_store = 1; sq_valid = 1; sq_addr = 32'h40; sq_wmask = 4'h1; sq_wdata = 32'hA5;
    ld_req = 1; ld_addr = 32'h3000; ld_rmask = 4'h3;
    #2 chk("prio_gnt_idle", ld_gnt, 0);
    cyc();
    rob_head_store = 0; sq_valid = 0; dmem_resp = 1;
    #2 chk("prio_gnt_wait", ld_gnt, 0);
    cyc();
    dmem_resp = 0;
    #2 chk("prio_done", store_done, 1);
    chk("prio_gnt_done", ld_gnt, 0);
    cyc();
    #2 chk("prio_gnt_after", ld_gnt, 1);
    cyc();
    ld_req = 0; dmem_resp = 1; dmem_rdata = 32'h0BAD_F00D;
    #2 chk("prio_ld_resp", ld_resp, 1);
    cyc();
    dmem_resp = 0;

    // Plain load.
    ld_req = 1; ld_addr = 32'h2000; ld_rmask = 4'hF;
    #2 chk("ld_gnt_pulse", ld_gnt, 1);
    cyc();
    ld_req = 0;
    #2 chk("ld_gnt_wait", ld_gnt, 0);
    chk("ld_dmem_addr", dmem_addr, 32'h2000);
    chk("ld_dmem_rmask", dmem_rmask, 4'hF);
    cyc();
    dmem_resp = 1; dmem_rdata = 32'h1234_5678;
    #2 chk("ld_resp", ld_resp, 1);
    chk("ld_rdata", ld_rdata, 32'h1234_5678);
    cyc();
    dmem_resp = 0;
    #2 chk("ld_resp_once", ld_resp, 0);

    // Flush one cycle after grant, response two cycles after the flush.
    cyc();
    ld_req = 1; ld_addr = 32'h2004; ld_rmask = 4'hF;
    #2 chk("drop_gnt", ld_gnt, 1);
    cyc();
    ld_req = 0; flush = 1;
    #2 chk("drop_resp0", ld_resp, 0);
    cyc();
    flush = 0;
    #2 chk("drop_resp1", ld_resp, 0);
    chk("drop_rmask_held", dmem_rmask, 4'hF);
    cyc();
    dmem_resp = 1; dmem_rdata = 32'hCAFE_0001;
    #2 chk("drop_resp2", ld_resp, 0);
    cyc();
    dmem_resp = 0; ld_req = 1; ld_addr = 32'h2008;
    #2 chk("drop_regrant", ld_gnt, 1);
    cyc();
    ld_req = 0; dmem_resp = 1;
    cyc();
    dmem_resp = 0;

    // Flush and response in the same LD_WAIT cycle.
    ld_req = 1; ld_addr = 32'h200C;
    cyc();
    ld_req = 0; flush = 1; dmem_resp = 1; dmem_rdata = 32'hCAFE_0002;
    #2 chk("fr_resp", ld_resp, 0);
    cyc();
    flush = 0; dmem_resp = 0; ld_req = 1;
    #2 chk("fr_idle_gnt", ld_gnt, 1);
    cyc();
    ld_req = 0; dmem_resp = 1;
    cyc();
    dmem_resp = 0;

    // Reset pulse during ST_WAIT, then a stale response.
    rob_head_store = 1; sq_valid = 1; sq_addr = 32'h80; sq_wmask = 4'hF; sq_wdata = 32'h77;
    cyc();
    rob_head_store = 0; sq_valid = 0;
    #2 chk("rst_pre_wmask", dmem_wmask, 4'hF);
    cyc();
    rst_n = 0;
    #1 check_all();
    chk("rst_wmask", dmem_wmask, 0);
    chk("rst_addr", dmem_addr, 0);
    cyc();
    rst_n = 1; dmem_resp = 1;
    #2 chk("rst_stale_done0", store_done, 0);
    cyc();
    dmem_resp = 0;
    #2 chk("rst_stale_done1", store_done, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      cyc();
      rst_n          = ($urandom_range(0, 199) != 0);
      rob_head_store = ($urandom_range(0, 3) == 0);
      sq_valid       = ($urandom_range(0, 1) == 0);
      sq_addr        = $urandom;
      sq_wdata       = $urandom;
      sq_wmask       = 4'($urandom);
      sq_rs1_rdata   = $urandom;
      sq_rs2_rdata   = $urandom;
      ld_req         = ($urandom_range(0, 1) == 0);
      ld_addr        = $urandom;
      ld_rmask       = 4'($urandom);
      flush          = ($urandom_range(0, 9) == 0);
      dmem_resp      = ($urandom_range(0, 4) < 2);
      dmem_rdata     = $urandom;
      if (!rst_n) #1 check_all();
    end
    cyc();
    rst_n = 1; rob_head_store = 0; sq_valid = 0; ld_req = 0; flush = 0; dmem_resp = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_commit_ctrl.md
STORE_COMMIT_CTRL -- requirements
Module: store_commit_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port rob_head_store, input, 1 bit: ROB head is a valid store awaiting commit.
REQ-004 SHALL have ports sq_valid (in, 1), sq_addr (in, 32), sq_wdata (in, 32), sq_wmask (in, 4), sq_rs1_rdata (in, 32), sq_rs2_rdata (in, 32) and sq_dequeue (out, 1): the store-queue head and its pop strobe.
REQ-005 SHALL have ports ld_req (in, 1), ld_addr (in, 32), ld_rmask (in, 4), ld_gnt (out, 1), ld_resp (out, 1) and ld_rdata (out, 32): the load-unit requester.
REQ-006 SHALL have port flush, input, 1 bit: the ROB flush pulse from commit.
REQ-007 SHALL have ports dmem_addr (out, 32), dmem_rmask (out, 4), dmem_wmask (out, 4), dmem_wdata (out, 32), dmem_rdata (in, 32) and dmem_resp (in, 1): the shared data-cache port.
REQ-008 SHALL have ports store_done (out, 1) and store_monitor_mem_addr, store_monitor_mem_wmask, store_monitor_mem_wdata, store_monitor_rs1_rdata and store_monitor_rs2_rdata (out, 32/4/32/32/32): the commit-path store completion.

Function
REQ-009 SHALL implement the FSM states IDLE, ST_WAIT, ST_DONE, LD_WAIT and LD_DROP.
REQ-010 SHALL treat a store as eligible in IDLE when rob_head_store and sq_valid are both 1.
REQ-011 SHALL, in IDLE with an eligible store, latch the sq_* fields into internal registers and go to ST_WAIT; stores take priority over ld_req.
REQ-012 SHALL, in IDLE with no eligible store and ld_req=1 and flush=0, pulse ld_gnt for one cycle, latch ld_addr/ld_rmask and go to LD_WAIT.
REQ-013 SHALL drive ld_gnt only in IDLE, so ld_gnt is 0 in every other state.
REQ-014 SHALL, in ST_WAIT, drive dmem_addr, dmem_wmask and dmem_wdata from the latched values and dmem_rmask=0, holding them stable until dmem_resp.
REQ-015 SHALL, in LD_WAIT and LD_DROP, drive dmem_addr and dmem_rmask from the latched values and dmem_wmask=0, holding them stable until dmem_resp.
REQ-016 SHALL drive dmem_rmask=0 and dmem_wmask=0 in IDLE and ST_DONE; dmem_addr and dmem_wdata are don't-care there.
REQ-017 SHALL ignore dmem_resp in IDLE and ST_DONE.
REQ-018 SHALL move ST_WAIT to ST_DONE on dmem_resp.
REQ-019 SHALL, in ST_DONE, assert store_done and sq_dequeue for exactly one cycle, with the store_monitor_* outputs equal to the latched values, then return to IDLE.
REQ-020 SHALL keep store_done asserted only in ST_DONE, so at most one store commits per ST_DONE visit.
REQ-021 SHALL NOT cancel a store in progress on flush: a committing store is architecturally retired.
REQ-022 SHALL, in LD_WAIT on dmem_resp with flush=0, pulse ld_resp for one cycle with ld_rdata=dmem_rdata and return to IDLE.
REQ-023 SHALL, in LD_WAIT on flush without dmem_resp, go to LD_DROP.
REQ-024 SHALL, in LD_WAIT on flush and dmem_resp in the same cycle, suppress ld_resp and return to IDLE.
REQ-025 SHALL, in LD_DROP on dmem_resp, return to IDLE without asserting ld_resp.
REQ-026 SHALL make the minimum store latency, from eligibility to store_done, 1 cycle + cache latency + 1 cycle.

Reset
REQ-027 SHALL, while rst_n=0, force the FSM to IDLE and clear all latched registers to 0, regardless of the clock.
REQ-028 SHALL drive every output to 0 during and immediately after reset.
REQ-029 SHALL abandon any outstanding dmem request on reset; the cache is reset by the same rst_n.

Structure
REQ-030 SHALL define the FSM state enum as a shared package typedef (store_ctrl_state_t) in rv32i_types.
REQ-031 SHALL take the store opcode from the existing op_b_store constant in rv32i_types.
REQ-032 SHALL be a single module with no sub-modules; the latched request is one packed struct register.

Verification
REQ-033 SHALL verify: store eligible with addr=0x1000_0004, wmask=4'b1100, wdata=0xDEAD_BEEF, and dmem_resp 3 cycles after the request -> dmem_wmask=4'b1100 held 3 cycles, then store_done=1 and sq_dequeue=1 for exactly 1 cycle with the monitor outputs matching.
REQ-034 SHALL verify: store eligible and ld_req=1 in the same IDLE cycle -> the store is served first, ld_gnt=0 until the cycle after ST_DONE, then the load is granted.
REQ-035 SHALL verify: load to addr=0x2000, rmask=4'hF, dmem_rdata=0x1234_5678 -> ld_gnt pulse, then ld_resp=1 with ld_rdata=0x1234_5678.
REQ-036 SHALL verify: flush 1 cycle after ld_gnt with dmem_resp 2 cycles later -> LD_DROP is entered, ld_resp stays 0, FSM returns to IDLE, and a new ld_req is granted the next cycle.
REQ-037 SHALL verify: flush and dmem_resp in the same LD_WAIT cycle -> ld_resp=0 and FSM returns to IDLE.
REQ-038 SHALL verify: rst_n deasserted for 1 cycle mid-ST_WAIT -> all outputs 0 immediately, and no store_done follows the stale dmem_resp.
